// File: rtl/online_ccm_serial.sv
// Digit-serial online multiplier by a constant: Y = C*X on borrow-save digits, MSD first.
// The output lags the input by DELTA digits, and the residual stays bounded for any legal COEF.
module online_ccm_serial #(
    parameter int unsigned   N     = 8,
    parameter int unsigned   CW    = 4,
    parameter logic [CW-1:0] COEF  = 4'b0110,
    parameter int unsigned   DELTA = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] x_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] y_out,
    output logic       busy,
    output logic       done
);

    localparam int unsigned WW      = CW + DELTA + 3;
    localparam int unsigned FW      = CW + DELTA - 1;
    localparam int unsigned CNTW    = $clog2(N + DELTA + 1);
    localparam int unsigned RUN_LEN = N - DELTA;

    localparam logic signed [WW-1:0] ONE  = WW'(1) << FW;
    localparam logic signed [WW-1:0] HALF = WW'(1) << (FW - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]           state, state_d;
    logic signed [WW-1:0] w_q, w_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [1:0]           y_q, y_d;

    logic signed [WW-1:0] coef_ext, term, v, w_sel;
    logic [1:0]           x_eff, digit;

    // The residual carries FW fraction bits, so C*x*2^-DELTA is exactly COEF*x in residual LSBs.
    assign coef_ext = {{(WW-CW){COEF[CW-1]}}, COEF};

    // One recurrence step: v = 2w + C*x*2^-DELTA, then digit selection at +/-1/2.
    always_comb begin
        term  = '0;
        digit = 2'b00;
        x_eff = (state == S_FLUSH) ? 2'b00 : x_in;
        unique case (x_eff)
            2'b10:   term = coef_ext;
            2'b01:   term = -coef_ext;
            default: term = '0;
        endcase
        v = (w_q <<< 1) + term;
        if (v >= HALF) begin
            digit = 2'b10;
            w_sel = v - ONE;
        end else if (v < -HALF) begin
            digit = 2'b01;
            w_sel = v + ONE;
        end else begin
            digit = 2'b00;
            w_sel = v;
        end
    end

    // The current digit is visible while it is offered; otherwise the last transferred digit is held.
    assign y_out = out_valid ? digit : y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            w_q   <= '0;
            cnt_q <= '0;
            y_q   <= 2'b00;
        end else begin
            state <= state_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
            y_q   <= y_d;
        end
    end

    // Next state, datapath enables and handshake outputs.
    always_comb begin
        state_d   = state;
        w_d       = w_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    w_d     = '0;
                    cnt_d   = '0;
                    y_d     = 2'b00;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                // Leading digits only accumulate: no selection until DELTA digits are in.
                if (in_valid) begin
                    w_d   = v;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(DELTA - 1)) begin
                        cnt_d   = '0;
                        state_d = (RUN_LEN == 0) ? S_FLUSH : S_RUN;
                    end
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                in_ready  = out_ready;
                out_valid = in_valid;
                if (in_valid && out_ready) begin
                    w_d   = w_sel;
                    y_d   = digit;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(RUN_LEN - 1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_d   = w_sel;
                    y_d   = digit;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(N - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_online_ccm_serial.sv
// Scoreboard bench for online_ccm_serial: expected digits and values are queued per frame
// and checked at each output transfer; covers latency, stalls, reset abort and start noise.
module tb_online_ccm_serial;

    localparam int N     = 8;
    localparam int CW    = 4;
    localparam logic [CW-1:0] COEF = 4'b0110;
    localparam int DELTA = 2;
    localparam int FRAC  = CW - 1 + DELTA;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, out_ready;
    logic [1:0] x_in;
    logic       in_ready, out_valid, busy, done;
    logic [1:0] y_out;

    int         tests = 0;
    int         fails = 0;
    longint     cyc = 0;
    logic [1:0] exp_q[$];
    longint     val_q[$];
    logic [1:0] xd [N];
    int         ocnt = 0;
    longint     yacc = 0;
    longint     last_y = 0;
    bit         first_seen = 1'b0;
    longint     t_in0 = 0, t_out0 = 0, t_last = 0, t_done = 0;
    int         done_cnt = 0;
    int         frames_run = 0;

    online_ccm_serial #(.N(N), .CW(CW), .COEF(COEF), .DELTA(DELTA)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic int dval(input logic [1:0] d);
        case (d)
            2'b10:   return 1;
            2'b01:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic longint labs(input longint a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic check(input string tag, input longint obs, input longint expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: online recurrence on integers scaled by 2^FRAC, plus exact C*X scaled by 2^(N+CW-1).
    task automatic push_frame();
        int     c, xv;
        longint w, v, xint;
        c = int'(COEF);
        if (COEF[CW-1]) c -= (1 << CW);
        w = 0;
        for (int k = 0; k < DELTA; k++) w = 2 * w + c * dval(xd[k]);
        for (int j = 0; j < N; j++) begin
            xv = (j + DELTA < N) ? dval(xd[j + DELTA]) : 0;
            v  = 2 * w + c * xv;
            if (v >= (1 << (FRAC - 1))) begin
                exp_q.push_back(2'b10);
                w = v - (1 << FRAC);
            end else if (v < -(1 << (FRAC - 1))) begin
                exp_q.push_back(2'b01);
                w = v + (1 << FRAC);
            end else begin
                exp_q.push_back(2'b00);
                w = v;
            end
        end
        xint = 0;
        for (int k = 0; k < N; k++) xint = 2 * xint + dval(xd[k]);
        val_q.push_back(c * xint);
    endtask

    // Output monitor: pops the scoreboard on every transfer and checks each completed frame's value.
    always @(negedge clk) begin
        longint cx;
        logic [1:0] e;
        if (rst) begin
            ocnt       = 0;
            yacc       = 0;
            first_seen = 1'b0;
        end else begin
            if (out_valid && !first_seen) begin
                t_out0     = cyc;
                first_seen = 1'b1;
            end
            if (out_valid && out_ready) begin
                tests++;
                assert (exp_q.size() > 0) else begin
                    fails++;
                    $error("FAIL sb_underflow: observed digit %b with empty queue", y_out);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("digit", longint'(y_out), longint'(e));
                end
                yacc = 2 * yacc + dval(y_out);
                ocnt++;
                if (ocnt == N) begin
                    t_last = cyc;
                    last_y = yacc;
                    if (val_q.size() > 0) begin
                        cx = val_q.pop_front();
                        check("value_bound", (labs(cx - yacc * (1 << (CW - 1))) <= (1 << (CW - 1))) ? 1 : 0, 1);
                    end
                    ocnt       = 0;
                    yacc       = 0;
                    first_seen = 1'b0;
                end
            end
            if (done) begin
                t_done = cyc;
                done_cnt++;
            end
        end
    end

    // Drives one frame from xd; abort_at > 0 stops once that many output digits have transferred.
    task automatic run_frame(input bit stall, input bit noise, input int abort_at);
        int idx, budget;
        bit fin;
        push_frame();
        idx = 0; budget = 0; fin = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        in_valid  = stall ? 1'($urandom_range(0, 1)) : 1'b0;
        x_in      = xd[0];
        out_ready = 1'b1;
        while (!fin) begin
            @(posedge clk); #1;
            start = noise;
            if (idx < N) begin
                in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                x_in     = xd[idx];
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                x_in     = 2'($urandom);
            end
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) begin
                if (idx == 0) t_in0 = cyc;
                idx++;
            end
            budget++;
            if (done) fin = 1'b1;
            else if (abort_at > 0 && ocnt >= abort_at) fin = 1'b1;
            else if (budget >= 400) begin
                tests++;
                fails++;
                $error("FAIL frame_timeout: observed %0d cycles without done, expected fewer than 400", budget);
                fin = 1'b1;
            end
        end
        @(posedge clk); #1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (abort_at == 0) begin
            frames_run++;
            check("inputs_consumed", idx, N);
            check("done_count", done_cnt, frames_run);
            check("idle_after", longint'(busy), 0);
            check("sb_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_in = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_y_out", longint'(y_out), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        rst = 1'b0;

        // in_valid while idle must not start anything
        in_valid = 1'b1; x_in = 2'b10; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_in_ready", longint'(in_ready), 0);
        check("idle_out_valid", longint'(out_valid), 0);
        check("idle_busy", longint'(busy), 0);
        in_valid = 1'b0; out_ready = 1'b0;

        // X = 0.5 -> Y = 0.375 (96/256), latency DELTA, done one cycle after the last digit
        foreach (xd[k]) xd[k] = 2'b00;
        xd[0] = 2'b10;
        run_frame(1'b0, 1'b0, 0);
        check("latency", t_out0 - t_in0, 2);
        check("done_delay", t_done - t_last, 1);
        check("half_value", last_y, 96);

        // X = all -1 digits -> Y within 2^-8 of -0.7470703125 (-765/1024)
        foreach (xd[k]) xd[k] = 2'b01;
        run_frame(1'b0, 1'b0, 0);
        check("allneg_value", (labs(4 * last_y + 765) <= 4) ? 1 : 0, 1);

        // X = all +1 digits, code 11 treated as zero, then start noise during the frame
        foreach (xd[k]) xd[k] = 2'b10;
        run_frame(1'b1, 1'b0, 0);
        foreach (xd[k]) xd[k] = 2'b11;
        run_frame(1'b0, 1'b0, 0);
        check("zero_value", last_y, 0);
        foreach (xd[k]) xd[k] = 2'($urandom);
        run_frame(1'b0, 1'b1, 0);

        // reset during RUN after four output digits, then a clean frame
        foreach (xd[k]) xd[k] = 2'($urandom);
        run_frame(1'b0, 1'b0, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", longint'(in_ready), 0);
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_y_out", longint'(y_out), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        rst = 1'b0;
        exp_q.delete();
        val_q.delete();
        foreach (xd[k]) xd[k] = 2'b10;
        xd[N-1] = 2'b01;
        run_frame(1'b0, 1'b0, 0);

        // random digits with random stalls on both sides, occasionally with start noise
        for (int f = 0; f < 1000; f++) begin
            foreach (xd[k]) xd[k] = 2'($urandom);
            run_frame(1'b1, (f % 7) == 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/online_ccm_serial.md
ONLINE_CCM_SERIAL -- requirements
Module: online_ccm_serial

Interface
REQ-001 SHALL have parameter N, default 8: digits per operand frame (N >= 2).
REQ-002 SHALL have parameter CW, default 4: coefficient width in bits.
REQ-003 SHALL have parameter COEF, default 4'b0110: signed CW-bit fraction, value COEF/2^(CW-1) (default 0.75); the most negative code is illegal.
REQ-004 SHALL have parameter DELTA, default 2: online delay in digits (DELTA >= 2).
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port start, input, 1: begins a frame when idle.
REQ-008 SHALL have port in_valid, input, 1: x_in holds a valid digit.
REQ-009 SHALL have port in_ready, output, 1: block accepts a digit this cycle.
REQ-010 SHALL have port x_in, input, 2: borrow-save digit {p,n}, value p-n, MSD first.
REQ-011 SHALL have port out_valid, output, 1: y_out holds a valid digit.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts y_out.
REQ-013 SHALL have port y_out, output, 2: result digit {p,n}, MSD first.
REQ-014 SHALL have port busy, output, 1: frame in progress.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after the last output digit transfers.

Function
REQ-016 SHALL compute Y = C*X digit-serially, with X = sum x_j*2^-j and Y = sum y_j*2^-j for j = 1..N.
REQ-017 SHALL use states IDLE, FILL, RUN, FLUSH, DONE.
REQ-018 IDLE: in_ready=0, out_valid=0; start=1 SHALL clear the residual and the digit counter and go to FILL.
REQ-019 FILL: in_ready=1; SHALL consume DELTA input digits (one per in_valid cycle) without producing output, then go to RUN.
REQ-020 RUN: SHALL consume one input digit and emit one output digit per cycle only when in_valid=1 and out_ready=1; in_ready = out_ready; out_valid = in_valid.
REQ-021 FLUSH: in_ready=0; SHALL inject x=0 internally and emit the last DELTA digits, one per out_ready cycle; after the N-th output digit transfers, go to DONE.
REQ-022 DONE: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-023 Each output step SHALL compute v = 2*w + C*x_(j+DELTA)*2^-DELTA; y_j = +1 if v >= 1/2, -1 if v < -1/2, else 0; w = v - y_j.
REQ-024 The residual SHALL be two's complement with at least CW+DELTA+3 bits and SHALL never overflow for legal COEF.
REQ-025 Output digit encoding SHALL be +1=2'b10, 0=2'b00, -1=2'b01; input code 2'b11 SHALL be treated as 0.
REQ-026 With no stalls, latency SHALL be DELTA cycles from the first input digit to the first output digit, and a frame SHALL take N+DELTA transfer cycles.
REQ-027 start outside IDLE SHALL be ignored; in_valid in IDLE, FLUSH or DONE SHALL be ignored.
REQ-028 Value requirement: |C*X - Y| <= 2^-N for every legal X in (-1,1).
REQ-029 Stall (in_valid=0 or out_ready=0) SHALL hold all state, y_out and the digit count unchanged.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, residual=0, counter=0, in_ready=0, out_valid=0, y_out=2'b00, busy=0, done=0, overriding any other input.
REQ-031 rst mid-frame SHALL discard the partial frame; the next start SHALL begin a clean frame.

Verification
REQ-032 COEF=0.75, N=8, X digits 1,0,0,0,0,0,0,0 (0.5), no stalls -> first out_valid 2 cycles after the first digit, Y value 0.375 within 2^-8, done 1 cycle after the 8th output digit.
REQ-033 COEF=0.75, X = all -1 digits (-0.99609375) -> Y value within 2^-8 of -0.7470703125; no residual overflow.
REQ-034 Random out_ready/in_valid stalls (50%) over 1000 random frames -> Y value identical to the unstalled run for every frame.
REQ-035 rst asserted during RUN at digit 4, then start -> all outputs 0 the cycle after rst; the following frame is correct.
REQ-036 start pulsed during RUN and FLUSH -> ignored; frame count and results are unchanged.
